// File: rtl/dcfeb_pkt_rd_arb_if.sv
// dcfeb_pkt_rd_arb_if
//   Bundles the FIFO-side and consumer-side signals of the DCFEB packet read-out
//   arbiter. The master modport belongs to the arbiter. The slave modport belongs to
//   the environment, which is the FIFOs plus the downstream consumer.
//
//   FEB_EN      per-FEB enable mask
//   PKT_AVAIL   FIFO i holds at least one complete packet
//   FIFO_EMPTY  FWFT empty flags
//   FIFO_DOUT   FWFT data, word i at [18i+17:18i]; bit17 last, bit16 CRC good
//   FIFO_RDEN   pop strobes, one-hot or zero
//   PKT_DONE    pulse when the last word of FIFO i's packet is popped
//   OUT_DATA / OUT_VALID / OUT_RDY / OUT_LAST / OUT_CRC_ERR / OUT_TRUNC
//               single-stage output word with valid/ready handshake
//   GRANT_ID    index of the granted FEB
//   BUSY        arbiter not idle
interface dcfeb_pkt_rd_arb_if #(
    parameter int NFEB = 7
);
    logic [NFEB-1:0]    FEB_EN;
    logic [NFEB-1:0]    PKT_AVAIL;
    logic [NFEB-1:0]    FIFO_EMPTY;
    logic [NFEB*18-1:0] FIFO_DOUT;
    logic [NFEB-1:0]    FIFO_RDEN;
    logic [NFEB-1:0]    PKT_DONE;
    logic [15:0]        OUT_DATA;
    logic               OUT_VALID;
    logic               OUT_RDY;
    logic               OUT_LAST;
    logic               OUT_CRC_ERR;
    logic               OUT_TRUNC;
    logic [2:0]         GRANT_ID;
    logic               BUSY;

    modport master (
        input  FEB_EN, PKT_AVAIL, FIFO_EMPTY, FIFO_DOUT, OUT_RDY,
        output FIFO_RDEN, PKT_DONE, OUT_DATA, OUT_VALID, OUT_LAST, OUT_CRC_ERR,
               OUT_TRUNC, GRANT_ID, BUSY
    );

    modport slave (
        output FEB_EN, PKT_AVAIL, FIFO_EMPTY, FIFO_DOUT, OUT_RDY,
        input  FIFO_RDEN, PKT_DONE, OUT_DATA, OUT_VALID, OUT_LAST, OUT_CRC_ERR,
               OUT_TRUNC, GRANT_ID, BUSY
    );
endinterface

// File: rtl/dcfeb_pkt_rd_arb.sv
// dcfeb_pkt_rd_arb
//   Round-robin read-out arbiter for the per-DCFEB packet FIFOs. It grants one FIFO at
//   a time and streams exactly one whole packet through a single-stage output register
//   with back-pressure. Packets longer than MAX_WORDS are cut. The word that hits the
//   budget is flagged OUT_LAST and OUT_TRUNC, and the rest of that packet is drained
//   from the FIFO without being forwarded.
//
//   CLK  system clock
//   RST  asynchronous active-high reset
//   bus  dcfeb_pkt_rd_arb_if.master (FIFO side and consumer side, see interface)
module dcfeb_pkt_rd_arb #(
    parameter int NFEB      = 7,
    parameter int MAX_WORDS = 812
) (
    input logic                CLK,
    input logic                RST,
    dcfeb_pkt_rd_arb_if.master bus
);

    localparam logic [10:0] LAST_WC = 11'(MAX_WORDS - 1);
    localparam logic [10:0] WC_SAT  = '1;

    typedef enum logic [2:0] {StIdle, StArb, StXfer, StDiscard, StDone} state_t;

    state_t      state_q, state_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;
    logic [2:0]  grant_q, grant_d;
    logic [10:0] wc_q, wc_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        out_crc_err_q, out_crc_err_d;
    logic        out_trunc_q, out_trunc_d;

    logic [NFEB-1:0] req;
    logic [NFEB-1:0] grant_oh;
    logic [17:0]     sel_word;
    logic            sel_empty;
    logic            arb_found;
    logic [2:0]      arb_idx;
    logic [2:0]      cand;
    logic            slot_free;
    logic            pop;
    logic            done_pulse;

    assign req       = bus.PKT_AVAIL & bus.FEB_EN;
    assign slot_free = !out_valid_q || bus.OUT_RDY;

    // Mux the granted FIFO's head word and empty flag.
    always_comb begin
        sel_word  = '0;
        sel_empty = 1'b1;
        grant_oh  = '0;
        for (int i = 0; i < NFEB; i++) begin
            if (grant_q == 3'(i)) begin
                sel_word    = bus.FIFO_DOUT[18*i +: 18];
                sel_empty   = bus.FIFO_EMPTY[i];
                grant_oh[i] = 1'b1;
            end
        end
    end

    // The first requester found circularly after rr_ptr wins. The search starts at
    // rr_ptr+1, so the FEB just served ranks last.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NFEB; k++) begin
            cand = 3'((int'(rr_ptr_q) + k) % NFEB);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        wc_d          = wc_q;
        pop           = 1'b0;
        done_pulse    = 1'b0;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        out_crc_err_d = out_crc_err_q;
        out_trunc_d   = out_trunc_q;
        // Acceptance empties the slot unless a pop below reloads it.
        out_valid_d   = out_valid_q && !bus.OUT_RDY;

        unique case (state_q)
            StIdle: begin
                if (req != '0) state_d = StArb;
            end
            StArb: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    wc_d    = '0;
                    state_d = StXfer;
                end else begin
                    state_d = StIdle;
                end
            end
            StXfer: begin
                if (!sel_empty && slot_free) begin
                    pop           = 1'b1;
                    wc_d          = (wc_q == WC_SAT) ? wc_q : wc_q + 11'd1;
                    out_valid_d   = 1'b1;
                    out_data_d    = sel_word[15:0];
                    out_last_d    = 1'b0;
                    out_crc_err_d = 1'b0;
                    out_trunc_d   = 1'b0;
                    if (sel_word[17]) begin
                        out_last_d    = 1'b1;
                        out_crc_err_d = !sel_word[16];
                        done_pulse    = 1'b1;
                        state_d       = StDone;
                    end else if (wc_q == LAST_WC) begin
                        // Budget reached: close the packet here, then drain the rest.
                        out_last_d  = 1'b1;
                        out_trunc_d = 1'b1;
                        state_d     = StDiscard;
                    end
                end
            end
            StDiscard: begin
                if (!sel_empty) begin
                    pop = 1'b1;
                    if (sel_word[17]) begin
                        done_pulse = 1'b1;
                        state_d    = StDone;
                    end
                end
            end
            StDone: begin
                if (!out_valid_q || bus.OUT_RDY) begin
                    rr_ptr_d = grant_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= StIdle;
            rr_ptr_q      <= 3'(NFEB - 1);
            grant_q       <= '0;
            wc_q          <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_crc_err_q <= 1'b0;
            out_trunc_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            wc_q          <= wc_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_crc_err_q <= out_crc_err_d;
            out_trunc_q   <= out_trunc_d;
        end
    end

    assign bus.FIFO_RDEN   = pop ? grant_oh : '0;
    assign bus.PKT_DONE    = done_pulse ? grant_oh : '0;
    assign bus.OUT_DATA    = out_data_q;
    assign bus.OUT_VALID   = out_valid_q;
    assign bus.OUT_LAST    = out_last_q;
    assign bus.OUT_CRC_ERR = out_crc_err_q;
    assign bus.OUT_TRUNC   = out_trunc_q;
    assign bus.GRANT_ID    = grant_q;
    assign bus.BUSY        = (state_q != StIdle);

endmodule

// File: doc/dcfeb_pkt_rd_arb.md
# dcfeb_pkt_rd_arb

Round-robin read-out arbiter for the per-DCFEB packet FIFOs fed by the DCFEB receiver frame processors. It grants one FIFO at a time and streams exactly one whole packet to a single downstream consumer, with back-pressure. It also enforces a per-packet word budget and reports CRC status and truncation. It sits between the NFEB receiver FIFOs and the DDU/PC data-formatting stage.

## Interface

Parameters:
- NFEB, 7, number of DCFEB FIFOs arbitrated.
- MAX_WORDS, 812, word budget per packet (includes last word).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- FEB_EN  in  NFEB  per-FEB enable mask; sampled only at arbitration.
- PKT_AVAIL  in  NFEB  FIFO i holds at least one complete packet.
- FIFO_EMPTY  in  NFEB  FWFT empty flags.
- FIFO_DOUT  in  NFEB*18  FWFT data; word i at [18i+17:18i].
  - bit17 = last word of packet.
  - bit16 = CRC good (meaningful on last word).
  - [15:0] = data.
- FIFO_RDEN  out  NFEB  pop strobe, one-hot or zero.
- PKT_DONE  out  NFEB  one-cycle pulse when the last word of FIFO i's packet is popped; drives the packet counter decrement.
- OUT_DATA  out  16  output word.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_RDY  in  1  consumer accepts when OUT_VALID & OUT_RDY.
- OUT_LAST  out  1  last word of the output packet.
- OUT_CRC_ERR  out  1  qualifies OUT_LAST: bit16 of the last word was 0.
- OUT_TRUNC  out  1  qualifies OUT_LAST: packet was cut at MAX_WORDS.
- GRANT_ID  out  3  index of the granted FEB.
- BUSY  out  1  state != IDLE.

## Operation

- States: IDLE, ARB, XFER, DISCARD, DONE.
- Output register: a single stage (OUT_*). It loads on pop. It clears OUT_VALID on acceptance unless reloaded in the same cycle.
- Pop rule in XFER: FIFO_RDEN[g] = !FIFO_EMPTY[g] & (!OUT_VALID | OUT_RDY). No pop in any other state except DISCARD.

State transitions:
- IDLE: req = PKT_AVAIL & FEB_EN. If req != 0, go to ARB.
- ARB (one cycle): g = first set bit of req, searching circularly from rr_ptr+1. Register g into GRANT_ID; clear word counter wc; go to XFER.
  - If req dropped to 0 during ARB, return to IDLE.
- XFER: each pop increments wc (11-bit, saturating).
  - Popped word with bit17=1: OUT_LAST=1, OUT_CRC_ERR=!bit16, PKT_DONE[g] pulse; go to DONE.
  - Popped word with wc == MAX_WORDS-1 and bit17=0: load it with OUT_LAST=1, OUT_TRUNC=1, OUT_CRC_ERR=0; go to DISCARD.
- DISCARD: FIFO_RDEN[g] = !FIFO_EMPTY[g]; nothing is forwarded. The pop with bit17=1 pulses PKT_DONE[g]; go to DONE.
- DONE: wait until the output register is empty or the last word is accepted. Then rr_ptr <= g; go to IDLE.
- FEB_EN deasserted mid-packet: the packet completes normally.
- An empty FIFO mid-packet (FWFT underflow gap) stalls XFER; there is no timeout.

Reset values:
- All outputs are 0.
- rr_ptr = NFEB-1, so FEB 0 wins first.
- State is IDLE; wc = 0.
- RST mid-packet abandons the packet. The remainder stays in the FIFO; upstream flushing is not this block's job.

## Timing

- Request to first pop: PKT_AVAIL seen in IDLE at cycle n → ARB at n+1 → first FIFO_RDEN at n+2 → OUT_VALID at n+3.
- Sustained throughput: 1 word/cycle while OUT_RDY=1.
- PKT_DONE is asserted in the same cycle as the FIFO_RDEN that pops the last word.
- OUT_LAST is registered and appears one cycle after PKT_DONE.
- Packet-to-packet gap with OUT_RDY=1:
  - last-word pop at cycle m, DONE at m+1 (last word accepted then), IDLE at m+2, ARB at m+3, next pop at m+4.
  - Minimum gap between OUT_VALID words of different packets: 3 idle cycles.
- Under back-pressure, OUT_DATA and the OUT_* qualifiers hold stable while OUT_VALID & !OUT_RDY.
- FIFO_RDEN is never asserted to a FIFO whose FIFO_EMPTY=1, and never to any index other than GRANT_ID.

## Test plan

- Single packet: FEB2 holds 5 words (last word bit16=1), OUT_RDY=1 → OUT_VALID for 5 cycles starting at n+3, OUT_LAST on word 5, OUT_CRC_ERR=0, PKT_DONE[2] one pulse, GRANT_ID=2.
- Round robin: FEB0, FEB3 and FEB6 each hold a 4-word packet simultaneously after reset → output order 0, 3, 6. Then re-requesting FEB0 and FEB3 → order 0, 3 (rr_ptr=6 wraps).
- Back-pressure: 8-word packet, OUT_RDY toggles 1/0 each cycle → 8 words delivered in order, none duplicated or lost; FIFO_RDEN only when slot free; completes in 16 cycles ±1.
- CRC error and mask: FEB1 last word bit16=0 → OUT_CRC_ERR=1 with OUT_LAST. FEB_EN[4]=0 while PKT_AVAIL[4]=1 → FEB4 is never granted.
- Truncation: MAX_WORDS=812, 900-word packet → exactly 812 words out, word 812 carries OUT_LAST=1 and OUT_TRUNC=1. The remaining 88 words are popped silently; PKT_DONE is pulsed once, on word 900.
- Reset mid-transfer: RST asserted at word 3 of 10 → all outputs 0 immediately, state IDLE. After release with PKT_AVAIL[0]=1, FEB0 is granted first.
